dispatch8_n_sync: RTL and testbench
===================================

# dispatch8_n_sync

Synchronous 1-to-8 dispatcher: the transmit-side counterpart of the 8-to-1 merge arbiter. It accepts one handshaked stream of tagged words from the cache control path and steers each word to one of eight output lanes, selected by a 3-bit destination index. Each lane has a private 2-entry FIFO, so a stalled lane never blocks traffic bound for the other lanes. It sits between the merged request/retire stream and the eight per-way consumers.

## Interface
- DATA_WIDTH, 12, payload width per word
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- i_drive  input  1  input word valid (level)
- i_dest  input  3  destination lane index, 0..7
- i_data  input  DATA_WIDTH  input payload
- o_free  output  1  input ready; transfer occurs when i_drive & o_free on a clock edge
- o_driveNext_8  output  8  per-lane valid (bit k = lane k)
- o_data0..o_data7  output  DATA_WIDTH each  per-lane payload (head of lane FIFO)
- i_freeNext_8  input  8  per-lane ready from consumer; lane k pops on o_driveNext_8[k] & i_freeNext_8[k]
- o_count_8  output  16  packed 2-bit occupancy per lane (bits 2k+1:2k = lane k count, 0..2)
- i_bcast  input  1  present only with DISPATCH8_BCAST_EN (see Configuration)

## Operation
- Per lane: 2-entry FIFO (head, tail registers; count 0..2).
- o_free = (count[i_dest] != 2). This is a combinational function of i_dest and the registered counts only. It does not depend on i_drive.
- Push on an accepted transfer: the word is written into lane i_dest; that lane's count increments.
- Pop when o_driveNext_8[k] & i_freeNext_8[k]: lane k's head is removed; the tail, if any, moves to head; count decrements.
- Push and pop on the same lane in the same cycle: count unchanged, and order is preserved.
  - count 1: the new word becomes head.
  - count 2: the old tail becomes head and the new word becomes tail.
  - A full lane (count 2) with pop and i_drive in the same cycle does NOT accept, because o_free uses the pre-pop count. There is no ready-through-pop bypass.
- o_driveNext_8[k] = (count_k != 0). o_dataK = head_k; the value is undefined-but-stable (held) when count is 0.
- Ordering: strict FIFO per lane. There are no ordering guarantees across lanes.
- No arbitration is needed: at most one push per cycle, and any number of pops per cycle (up to 8).

## Timing
- Reset (rst high at an edge): all counts 0 and o_driveNext_8 = 8'h00. All head/tail registers and o_data0..7 are zeroed; o_count_8 = 16'h0000; o_free = 1.
- rst is dominant: a push or pop in the same cycle as rst is discarded.
- Latency: a word accepted at edge N is visible on o_driveNext_8/o_dataK after edge N (cycle N+1).
- Throughput: 1 word/cycle into any lane set, provided each target lane is drained at 1 word/cycle; sustained back-to-back to one lane with a consumer ready every cycle never stalls.
- o_driveNext_8[k] and o_dataK are held stable until popped, and must not change while valid and not ready.
- An out-of-range i_dest is not possible, because the field is 3 bits.
- i_dest and i_data are sampled only on an accepted edge. Values when i_drive is low are ignored.

## Configuration
- DISPATCH8_BCAST_EN defined:
  - adds the i_bcast port;
  - with i_drive & i_bcast, o_free = all 8 counts < 2, and i_dest is ignored;
  - on acceptance, the word is pushed into all 8 lanes in the same cycle;
  - same-cycle pops on any lane follow the normal push/pop rules.
- DISPATCH8_BCAST_EN undefined:
  - no i_bcast port and no broadcast logic;
  - behaviour is unicast only, as above.

## Test plan
- Reset: assert rst 2 cycles mid-traffic with lane 3 holding 2 words -> next cycle o_driveNext_8 = 8'h00, o_count_8 = 0, o_free = 1.
- Unicast ordering: push 0x001, 0x002 to lane 5 with i_freeNext_8 = 0 -> o_count_8[11:10] = 2, o_data5 = 0x001. Then raise i_freeNext_8[5] -> 0x001 then 0x002 on consecutive cycles, then valid drops.
- Full lane: lane 2 holding 2 words, i_drive with i_dest = 2 and pop on lane 2 the same cycle -> o_free = 0 and no push. The next cycle accepts (count goes 1 -> 2).
- Isolation: lane 0 full and stalled; stream 0x100..0x107 to lanes 1..7 -> all accepted back-to-back, and lane 0 is unaffected.
- Simultaneous push/pop: lane 4 count 1 (head 0xAAA), push 0xBBB while popping -> count stays 1, and o_data4 = 0xBBB next cycle.
- Broadcast (macro on): i_bcast with data 0x5A5 and all lanes empty -> o_driveNext_8 = 8'hFF with every o_dataK = 0x5A5. With lane 6 full, the broadcast stalls (o_free = 0) until lane 6 pops.

Source files
------------

// File: rtl/dispatch8_n_sync.sv
// rtl/dispatch8_n_sync.sv - 1-to-8 lane dispatcher with a private 2-entry FIFO per lane
// Optional broadcast push into all lanes is enabled by defining DISPATCH8_BCAST_EN.
module dispatch8_n_sync #(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_drive,
  input  logic [2:0]            i_dest,
  input  logic [DATA_WIDTH-1:0] i_data,
`ifdef DISPATCH8_BCAST_EN
  input  logic                  i_bcast,
`endif
  output logic                  o_free,
  output logic [7:0]            o_driveNext_8,
  output logic [DATA_WIDTH-1:0] o_data0,
  output logic [DATA_WIDTH-1:0] o_data1,
  output logic [DATA_WIDTH-1:0] o_data2,
  output logic [DATA_WIDTH-1:0] o_data3,
  output logic [DATA_WIDTH-1:0] o_data4,
  output logic [DATA_WIDTH-1:0] o_data5,
  output logic [DATA_WIDTH-1:0] o_data6,
  output logic [DATA_WIDTH-1:0] o_data7,
  input  logic [7:0]            i_freeNext_8,
  output logic [15:0]           o_count_8
);

  logic [DATA_WIDTH-1:0] head_q [8];
  logic [DATA_WIDTH-1:0] head_d [8];
  logic [DATA_WIDTH-1:0] tail_q [8];
  logic [DATA_WIDTH-1:0] tail_d [8];
  logic [1:0]            count_q [8];
  logic [1:0]            count_d [8];
  logic [7:0]            lane_full;
  logic [7:0]            push_en;
  logic [7:0]            pop_en;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      lane_full[k] = (count_q[k] == 2'd2);
    end
  end

  // Readiness looks only at registered counts, so a full lane never accepts through a same-cycle pop.
`ifdef DISPATCH8_BCAST_EN
  always_comb begin
    if (i_drive && i_bcast) o_free = ~(|lane_full);
    else                    o_free = ~lane_full[i_dest];
    for (int k = 0; k < 8; k++) begin
      push_en[k] = i_drive && o_free && (i_bcast || (i_dest == k[2:0]));
    end
  end
`else
  always_comb begin
    o_free = ~lane_full[i_dest];
    for (int k = 0; k < 8; k++) begin
      push_en[k] = i_drive && o_free && (i_dest == k[2:0]);
    end
  end
`endif

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      pop_en[k]  = (count_q[k] != 2'd0) && i_freeNext_8[k];
      head_d[k]  = head_q[k];
      tail_d[k]  = tail_q[k];
      count_d[k] = count_q[k];
      case ({push_en[k], pop_en[k]})
        2'b10: begin
          if (count_q[k] == 2'd0) head_d[k] = i_data;
          else                    tail_d[k] = i_data;
          count_d[k] = count_q[k] + 2'd1;
        end
        2'b01: begin
          head_d[k]  = tail_q[k];
          count_d[k] = count_q[k] - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever survives the pop.
          if (count_q[k] == 2'd1) begin
            head_d[k] = i_data;
          end else begin
            head_d[k] = tail_q[k];
            tail_d[k] = i_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (rst) begin
        head_q[k]  <= '0;
        tail_q[k]  <= '0;
        count_q[k] <= 2'd0;
      end else begin
        head_q[k]  <= head_d[k];
        tail_q[k]  <= tail_d[k];
        count_q[k] <= count_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      o_driveNext_8[k]      = (count_q[k] != 2'd0);
      o_count_8[2*k +: 2]   = count_q[k];
    end
  end

  assign o_data0 = head_q[0];
  assign o_data1 = head_q[1];
  assign o_data2 = head_q[2];
  assign o_data3 = head_q[3];
  assign o_data4 = head_q[4];
  assign o_data5 = head_q[5];
  assign o_data6 = head_q[6];
  assign o_data7 = head_q[7];

endmodule

// File: tb/tb_dispatch8_n_sync.sv
// tb/tb_dispatch8_n_sync.sv - directed self-checking bench for dispatch8_n_sync
module tb_dispatch8_n_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_drive;
  logic [2:0]  i_dest;
  logic [11:0] i_data;
`ifdef DISPATCH8_BCAST_EN
  logic        i_bcast;
`endif
  logic        o_free;
  logic [7:0]  o_driveNext_8;
  logic [11:0] o_data0, o_data1, o_data2, o_data3;
  logic [11:0] o_data4, o_data5, o_data6, o_data7;
  logic [7:0]  i_freeNext_8;
  logic [15:0] o_count_8;
  logic [11:0] dout [8];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dispatch8_n_sync #(.DATA_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .i_drive(i_drive), .i_dest(i_dest), .i_data(i_data),
`ifdef DISPATCH8_BCAST_EN
    .i_bcast(i_bcast),
`endif
    .o_free(o_free), .o_driveNext_8(o_driveNext_8),
    .o_data0(o_data0), .o_data1(o_data1), .o_data2(o_data2), .o_data3(o_data3),
    .o_data4(o_data4), .o_data5(o_data5), .o_data6(o_data6), .o_data7(o_data7),
    .i_freeNext_8(i_freeNext_8), .o_count_8(o_count_8)
  );

  assign dout[0] = o_data0;
  assign dout[1] = o_data1;
  assign dout[2] = o_data2;
  assign dout[3] = o_data3;
  assign dout[4] = o_data4;
  assign dout[5] = o_data5;
  assign dout[6] = o_data6;
  assign dout[7] = o_data7;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] dest, input logic [11:0] data);
    i_drive = 1'b1;
    i_dest  = dest;
    i_data  = data;
    tick();
    i_drive = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (o_driveNext_8 !== 8'h00 || o_count_8 !== 16'h0000 || o_free !== 1'b1 || o_data3 !== 12'h000) begin
      failures++;
      $display("FAIL reset_initial: valid=%h count=%h free=%b data3=%h expected 00/0000/1/000",
               o_driveNext_8, o_count_8, o_free, o_data3);
    end
    push(3'd3, 12'h333);
    push(3'd3, 12'h334);
    checks++;
    if (o_count_8 !== 16'h0080) begin
      failures++;
      $display("FAIL reset_prefill: count=%h expected 0080", o_count_8);
    end
    rst = 1'b1;
    i_drive = 1'b1; i_dest = 3'd3; i_data = 12'h335; i_freeNext_8 = 8'h08;
    tick(); tick();
    rst = 1'b0; i_drive = 1'b0; i_freeNext_8 = 8'h00;
    #1;
    checks++;
    if (o_driveNext_8 !== 8'h00 || o_count_8 !== 16'h0000 || o_free !== 1'b1 || o_data3 !== 12'h000) begin
      failures++;
      $display("FAIL reset_mid_traffic: valid=%h count=%h free=%b data3=%h expected 00/0000/1/000",
               o_driveNext_8, o_count_8, o_free, o_data3);
    end
  endtask

  task automatic test_unicast_order();
    i_freeNext_8 = 8'h00;
    push(3'd5, 12'h001);
    checks++;
    if (o_driveNext_8 !== 8'h20 || o_data5 !== 12'h001) begin
      failures++;
      $display("FAIL order_latency: valid=%h data5=%h expected 20/001", o_driveNext_8, o_data5);
    end
    push(3'd5, 12'h002);
    checks++;
    if (o_count_8[11:10] !== 2'd2 || o_data5 !== 12'h001) begin
      failures++;
      $display("FAIL order_full: count5=%0d data5=%h expected 2/001", o_count_8[11:10], o_data5);
    end
    i_freeNext_8 = 8'h20;
    tick();
    checks++;
    if (o_driveNext_8[5] !== 1'b1 || o_data5 !== 12'h002 || o_count_8[11:10] !== 2'd1) begin
      failures++;
      $display("FAIL order_second: valid5=%b data5=%h count5=%0d expected 1/002/1",
               o_driveNext_8[5], o_data5, o_count_8[11:10]);
    end
    tick();
    checks++;
    if (o_driveNext_8 !== 8'h00) begin
      failures++;
      $display("FAIL order_drained: valid=%h expected 00", o_driveNext_8);
    end
    i_freeNext_8 = 8'h00;
  endtask

  task automatic test_full_lane();
    push(3'd2, 12'h0A1);
    push(3'd2, 12'h0A2);
    i_drive = 1'b1; i_dest = 3'd2; i_data = 12'h0A3; i_freeNext_8 = 8'h04;
    #1;
    checks++;
    if (o_free !== 1'b0) begin
      failures++;
      $display("FAIL full_no_bypass: free=%b expected 0", o_free);
    end
    tick();
    i_freeNext_8 = 8'h00;
    #1;
    checks++;
    if (o_count_8[5:4] !== 2'd1 || o_data2 !== 12'h0A2 || o_free !== 1'b1) begin
      failures++;
      $display("FAIL full_after_pop: count2=%0d data2=%h free=%b expected 1/0A2/1",
               o_count_8[5:4], o_data2, o_free);
    end
    tick();
    i_drive = 1'b0;
    checks++;
    if (o_count_8[5:4] !== 2'd2 || o_data2 !== 12'h0A2) begin
      failures++;
      $display("FAIL full_retry_accept: count2=%0d data2=%h expected 2/0A2", o_count_8[5:4], o_data2);
    end
    i_freeNext_8 = 8'h04;
    tick();
    checks++;
    if (o_data2 !== 12'h0A3) begin
      failures++;
      $display("FAIL full_tail_order: data2=%h expected 0A3", o_data2);
    end
    tick();
    i_freeNext_8 = 8'h00;
  endtask

  task automatic test_isolation();
    push(3'd0, 12'h0F0);
    push(3'd0, 12'h0F1);
    for (int k = 1; k < 8; k++) begin
      i_drive = 1'b1; i_dest = 3'(k); i_data = 12'h100 + 12'(k);
      #1;
      checks++;
      if (o_free !== 1'b1) begin
        failures++;
        $display("FAIL iso_free_lane%0d: free=%b expected 1", k, o_free);
      end
      tick();
    end
    i_drive = 1'b0;
    checks++;
    if (o_driveNext_8 !== 8'hFF || o_count_8 !== 16'h5556 || o_data0 !== 12'h0F0) begin
      failures++;
      $display("FAIL iso_state: valid=%h count=%h data0=%h expected FF/5556/0F0",
               o_driveNext_8, o_count_8, o_data0);
    end
    for (int k = 1; k < 8; k++) begin
      checks++;
      if (dout[k] !== 12'h100 + 12'(k)) begin
        failures++;
        $display("FAIL iso_data%0d: got %h expected %h", k, dout[k], 12'h100 + 12'(k));
      end
    end
    i_freeNext_8 = 8'hFF;
    tick(); tick();
    i_freeNext_8 = 8'h00;
    checks++;
    if (o_driveNext_8 !== 8'h00) begin
      failures++;
      $display("FAIL iso_drain: valid=%h expected 00", o_driveNext_8);
    end
  endtask

  task automatic test_push_pop();
    push(3'd4, 12'hAAA);
    i_drive = 1'b1; i_dest = 3'd4; i_data = 12'hBBB; i_freeNext_8 = 8'h10;
    tick();
    i_drive = 1'b0; i_freeNext_8 = 8'h00;
    checks++;
    if (o_count_8[9:8] !== 2'd1 || o_data4 !== 12'hBBB) begin
      failures++;
      $display("FAIL pushpop: count4=%0d data4=%h expected 1/BBB", o_count_8[9:8], o_data4);
    end
    i_freeNext_8 = 8'h10;
    tick();
    i_freeNext_8 = 8'h00;
  endtask

  task automatic test_back_to_back();
    logic [11:0] w;
    i_freeNext_8 = 8'h40;
    for (int n = 0; n < 8; n++) begin
      w = 12'h600 + 12'(n);
      i_drive = 1'b1; i_dest = 3'd6; i_data = w;
      #1;
      checks++;
      if (o_free !== 1'b1) begin
        failures++;
        $display("FAIL b2b_stall%0d: free=%b expected 1", n, o_free);
      end
      tick();
      checks++;
      if (o_data6 !== w || o_count_8[13:12] !== 2'd1) begin
        failures++;
        $display("FAIL b2b_word%0d: data6=%h count6=%0d expected %h/1", n, o_data6, o_count_8[13:12], w);
      end
    end
    i_drive = 1'b0;
    tick();
    i_freeNext_8 = 8'h00;
    checks++;
    if (o_driveNext_8 !== 8'h00) begin
      failures++;
      $display("FAIL b2b_drain: valid=%h expected 00", o_driveNext_8);
    end
  endtask

`ifdef DISPATCH8_BCAST_EN
  task automatic test_bcast();
    i_bcast = 1'b1;
    push(3'd0, 12'h5A5);
    i_bcast = 1'b0;
    checks++;
    if (o_driveNext_8 !== 8'hFF || o_count_8 !== 16'h5555) begin
      failures++;
      $display("FAIL bcast_valid: valid=%h count=%h expected FF/5555", o_driveNext_8, o_count_8);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dout[k] !== 12'h5A5) begin
        failures++;
        $display("FAIL bcast_data%0d: got %h expected 5A5", k, dout[k]);
      end
    end
    i_freeNext_8 = 8'hFF;
    tick();
    i_freeNext_8 = 8'h00;
    push(3'd6, 12'h061);
    push(3'd6, 12'h062);
    i_bcast = 1'b1; i_drive = 1'b1; i_dest = 3'd1; i_data = 12'h3C3;
    #1;
    checks++;
    if (o_free !== 1'b0) begin
      failures++;
      $display("FAIL bcast_stall: free=%b expected 0", o_free);
    end
    tick();
    checks++;
    if (o_count_8 !== 16'h2000) begin
      failures++;
      $display("FAIL bcast_no_push: count=%h expected 2000", o_count_8);
    end
    i_freeNext_8 = 8'h40;
    tick();
    i_freeNext_8 = 8'h00;
    #1;
    checks++;
    if (o_free !== 1'b1) begin
      failures++;
      $display("FAIL bcast_unstall: free=%b expected 1", o_free);
    end
    tick();
    i_drive = 1'b0; i_bcast = 1'b0;
    checks++;
    if (o_count_8 !== 16'h6555 || o_data6 !== 12'h062 || o_data0 !== 12'h3C3) begin
      failures++;
      $display("FAIL bcast_after: count=%h data6=%h data0=%h expected 6555/062/3C3",
               o_count_8, o_data6, o_data0);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; i_drive = 1'b0; i_dest = 3'd0; i_data = 12'h000; i_freeNext_8 = 8'h00;
`ifdef DISPATCH8_BCAST_EN
    i_bcast = 1'b0;
`endif
    #2;
    test_reset();
    test_unicast_order();
    test_full_lane();
    test_isolation();
    test_push_pop();
    test_back_to_back();
`ifdef DISPATCH8_BCAST_EN
    test_bcast();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
